// File: rtl/decoder_3x8_pulse_if.sv
// Command and strobe bundle for decoder_3x8_pulse.
// The slave side is the decoder; the master side is the command source / strobe consumer.
interface decoder_3x8_pulse_if #(
    parameter int LEN_W = 4,
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_code;
    logic [LEN_W-1:0] in_len;
    logic             en;
    logic [7:0]       out;
    logic             done;
    logic             busy;
    logic [LVL_W-1:0] level;

    modport master (
        output in_valid, in_code, in_len, en,
        input  in_ready, out, done, busy, level
    );

    modport slave (
        input  in_valid, in_code, in_len, en,
        output in_ready, out, done, busy, level
    );
endinterface

// File: rtl/decoder_3x8_pulse.sv
// Queued 3-to-8 decoder: each command drives one strobe line for a programmed
// number of cycles, followed by a fixed all-zero gap before the next command.
module decoder_3x8_pulse #(
    parameter int LEN_W = 4,
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    decoder_3x8_pulse_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP + 1);
    localparam int ENT_W = 3 + LEN_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_GAP
    } state_t;

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [7:0]       r_out;
    logic             r_done;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_boundary;
    logic [2:0]       w_head_code;
    logic [LEN_W-1:0] w_head_len;
    logic [LEN_W-1:0] w_head_len_eff;

    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = bus.in_valid && !w_full;

    // Head entry is read combinationally so a pop edge can load the strobe directly.
    assign {w_head_code, w_head_len} = r_mem[r_rd_ptr];
    assign w_head_len_eff = (w_head_len == '0) ? LEN_W'(1) : w_head_len;

    // A new pulse may start from IDLE, or on the last cycle before IDLE would be
    // reached, so consecutive pulses are spaced by exactly GAP zero cycles.
    always_comb begin
        w_boundary = 1'b0;
        case (r_state)
            ST_IDLE:   w_boundary = 1'b1;
            ST_ACTIVE: w_boundary = (GAP == 0) && (r_cnt == LEN_W'(1));
            ST_GAP:    w_boundary = (r_gap_cnt == GAP_W'(1));
            default:   w_boundary = 1'b0;
        endcase
    end

    assign w_pop = bus.en && !w_empty && w_boundary;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_code, bus.in_len};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
            r_out     <= '0;
            r_done    <= 1'b0;
        end else if (w_pop) begin
            r_state   <= ST_ACTIVE;
            r_out     <= 8'b1 << w_head_code;
            r_cnt     <= w_head_len_eff;
            r_done    <= (w_head_len_eff == LEN_W'(1));
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                ST_ACTIVE: begin
                    if (r_cnt == LEN_W'(1)) begin
                        r_out  <= '0;
                        r_done <= 1'b0;
                        r_cnt  <= '0;
                        if (GAP == 0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= GAP_W'(GAP);
                        end
                    end else begin
                        r_cnt  <= r_cnt - LEN_W'(1);
                        r_done <= (r_cnt == LEN_W'(2));
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_W'(1)) begin
                        r_state   <= ST_IDLE;
                        r_gap_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    r_out  <= '0;
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = !w_full;
    assign bus.out      = r_out;
    assign bus.done     = r_done;
    assign bus.busy     = (r_state != ST_IDLE) || !w_empty;
    assign bus.level    = r_level;
endmodule

// File: tb/tb_decoder_3x8_pulse.sv
// Scoreboard bench for decoder_3x8_pulse: accepted commands queue their expected
// pulse; a negedge monitor checks each observed pulse, its done flag and the gap after it.
module tb_decoder_3x8_pulse;
    localparam int LEN_W = 4;
    localparam int DEPTH = 4;
    localparam int GAP   = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    decoder_3x8_pulse_if #(.LEN_W(LEN_W), .DEPTH(DEPTH)) bus ();

    decoder_3x8_pulse #(.LEN_W(LEN_W), .DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code_v;
        int len_v;
    } cmd_t;

    cmd_t sb_q[$];
    cmd_t mon_c;
    bit   saw_full = 1'b0;
    int   mon_left = 0;
    int   mon_gap  = 0;
    int   mon_code = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: expected pulses come only from the scoreboard queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_left = 0;
            mon_gap  = 0;
        end else begin
            check("onehot", 32'($countones(bus.out) <= 1), 1);
            check("ready_vs_level", bus.in_ready, (bus.level < DEPTH));
            if (bus.level == DEPTH) saw_full = 1'b1;
            if (mon_left == 0 && mon_gap == 0 && bus.out != 8'h00) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", bus.out, 0);
                end else begin
                    mon_c    = sb_q.pop_front();
                    mon_code = mon_c.code_v;
                    mon_left = mon_c.len_v;
                    $display("pulse code=%0d len=%0d at t=%0t", mon_code, mon_left, $time);
                end
            end
            if (mon_left > 0) begin
                check("pulse_out", bus.out, 1 << mon_code);
                check("pulse_done", bus.done, (mon_left == 1));
                mon_left--;
                if (mon_left == 0) mon_gap = GAP;
            end else if (mon_gap > 0) begin
                check("gap_out", bus.out, 0);
                check("gap_done", bus.done, 0);
                mon_gap--;
            end else begin
                check("idle_done", bus.done, 0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int code, input int len);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_code  = code[2:0];
        bus.in_len   = len[LEN_W-1:0];
        while (!bus.in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 300 cycles");
                bus.in_valid = 1'b0;
                return;
            end
        end
        sb_q.push_back('{code, (len == 0) ? 1 : len});
        $display("push code=%0d len=%0d at t=%0t", code, len, $time);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((bus.busy || sb_q.size() != 0) && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        cyc(2);
        check("drain_busy", bus.busy, 0);
        check("drain_sb_empty", sb_q.size(), 0);
    endtask

    task automatic wait_out(input logic [7:0] val);
        int n;
        n = 0;
        while (bus.out != val && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_out", bus.out, val);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_code  = '0;
        bus.in_len   = '0;
        bus.en       = 1'b1;
        rst_n        = 1'b0;
        cyc(3);
        check("rst_out", bus.out, 0);
        check("rst_done", bus.done, 0);
        check("rst_level", bus.level, 0);
        check("rst_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency and length of a single pulse
        send(5, 3);
        check("t1_level_after_push", bus.level, 1);
        check("t1_out_before_pop", bus.out, 0);
        cyc(1);
        check("t1_out_c1", bus.out, 8'h20);
        check("t1_done_c1", bus.done, 0);
        check("t1_level_c1", bus.level, 0);
        cyc(1);
        check("t1_out_c2", bus.out, 8'h20);
        check("t1_done_c2", bus.done, 0);
        cyc(1);
        check("t1_out_c3", bus.out, 8'h20);
        check("t1_done_c3", bus.done, 1);
        cyc(1);
        check("t1_out_gap", bus.out, 0);
        check("t1_busy_gap", bus.busy, 1);
        cyc(1);
        check("t1_busy_end", bus.busy, 0);

        // Eight consecutive single-cycle pulses; FIFO must fill
        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) send(i, 1);
        wait_idle(200);
        check("t2_saw_full", saw_full, 1);

        // Zero length is treated as one
        send(2, 0);
        cyc(1);
        check("t3_out", bus.out, 8'h04);
        check("t3_done", bus.done, 1);
        cyc(1);
        check("t3_out_after", bus.out, 0);
        wait_idle(50);

        // en gating
        @(negedge clk);
        bus.en = 1'b0;
        send(3, 2);
        send(6, 1);
        send(1, 4);
        cyc(5);
        check("t4_out_held", bus.out, 0);
        check("t4_level", bus.level, 3);
        @(negedge clk);
        bus.en = 1'b1;
        wait_idle(200);
        send(4, 6);
        send(7, 2);
        wait_out(8'h10);
        @(negedge clk);
        bus.en = 1'b0;
        cyc(20);
        check("t4_level_kept", bus.level, 1);
        check("t4_out_stopped", bus.out, 0);
        check("t4_busy_kept", bus.busy, 1);
        @(negedge clk);
        bus.en = 1'b1;
        wait_idle(200);

        // Full FIFO holds the source off without overwriting
        @(negedge clk);
        bus.en = 1'b0;
        send(0, 3);
        send(1, 2);
        send(2, 1);
        send(3, 5);
        check("t5_level_full", bus.level, 4);
        check("t5_ready_full", bus.in_ready, 0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_code  = 3'd5;
        bus.in_len   = LEN_W'(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_ready_hold", bus.in_ready, 0);
            check("t5_level_hold", bus.level, 4);
        end
        bus.en = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus.in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("t5_ready_recover", bus.in_ready, 1);
            sb_q.push_back('{5, 2});
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check("t5_level_refill", bus.level, 4);
        end
        wait_idle(300);

        // Simultaneous push and pop leaves level unchanged
        @(negedge clk);
        bus.en = 1'b0;
        send(6, 1);
        send(5, 2);
        send(4, 1);
        @(negedge clk);
        bus.en       = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_code  = 3'd7;
        bus.in_len   = LEN_W'(3);
        check("t5_pp_ready", bus.in_ready, 1);
        sb_q.push_back('{7, 3});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("t5_pp_level", bus.level, 3);
        check("t5_pp_out", bus.out, 8'h40);
        wait_idle(200);

        // Asynchronous reset mid-pulse
        send(6, 8);
        send(1, 2);
        wait_out(8'h40);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_out_async", bus.out, 0);
        check("t6_done_async", bus.done, 0);
        check("t6_level_async", bus.level, 0);
        check("t6_busy_async", bus.busy, 0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(20);
        check("t6_out_after", bus.out, 0);
        check("t6_level_after", bus.level, 0);
        check("t6_busy_after", bus.busy, 0);

        // Randomized commands with occasional en pauses
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                bus.en = 1'b0;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                bus.en = 1'b1;
            end
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        wait_idle(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
